// File: rtl/ic_resp_pkg.sv
// Shared types and defaults for the instruction-cache response buffer.
// Optional same-cycle bypass is enabled by defining IC_RESP_BUF_BYPASS_EN.
package ic_resp_pkg;

    localparam int IC_RESP_DATA_WIDTH = 32;
    localparam int IC_RESP_ID_WIDTH   = 4;
    localparam int IC_RESP_DEPTH_DEF  = 4;

    typedef struct packed {
        logic [IC_RESP_DATA_WIDTH-1:0] rdata;
        logic [IC_RESP_ID_WIDTH-1:0]   id;
    } ic_resp_t;

endpackage

// File: rtl/ic_resp_fifo.sv
// Response FIFO: storage, wrapping pointers and occupancy count.
// A push while full is ignored unless a pop happens in the same cycle.
module ic_resp_fifo
    import ic_resp_pkg::*;
#(
    parameter int WIDTH     = IC_RESP_DATA_WIDTH + IC_RESP_ID_WIDTH,
    parameter int DEPTH     = IC_RESP_DEPTH_DEF,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wen;
    logic             ren;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign ren   = pop & ~empty;
    assign wen   = push & (~full | ren);
    assign rdata = mem[rptr];

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (ren) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wen, ren})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ic_resp_buffer.sv
// Buffers merged I-cache responses and gates request issue with credits.
// Define IC_RESP_BUF_BYPASS_EN for a 0-cycle path when the FIFO is empty.
module ic_resp_buffer
    import ic_resp_pkg::*;
#(
    parameter  int DATA_WIDTH = IC_RESP_DATA_WIDTH,
    parameter  int ID_WIDTH   = IC_RESP_ID_WIDTH,
    parameter  int DEPTH      = IC_RESP_DEPTH_DEF,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_fire_i,
    output logic                  can_issue_o,
    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic [ID_WIDTH-1:0]   data_r_ID_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [ID_WIDTH-1:0]   resp_ID_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  err_o
);

    localparam int W = DATA_WIDTH + ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH:0]   DEPTH_X = (CNT_WIDTH + 1)'(DEPTH);

    logic [W-1:0]         head;
    logic                 full;
    logic                 empty;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] outstanding;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 unexpected;
    logic                 over_issue;

    ic_resp_fifo #(
        .WIDTH     (W),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({data_r_rdata_i, data_r_ID_i}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef IC_RESP_BUF_BYPASS_EN
    logic bypass;
    assign bypass       = empty & data_r_valid_i;
    assign resp_valid_o = ~empty | data_r_valid_i;
    assign pop          = ~empty & resp_ready_i;
    // A bypassed response consumed this cycle never touches the FIFO.
    assign push         = data_r_valid_i & ~(bypass & resp_ready_i);
    assign {resp_rdata_o, resp_ID_o} =
        bypass ? {data_r_rdata_i, data_r_ID_i} : head;
`else
    assign resp_valid_o = ~empty;
    assign pop          = ~empty & resp_ready_i;
    assign push         = data_r_valid_i;
    assign {resp_rdata_o, resp_ID_o} = head;
`endif

    // Credits: in-flight requests plus buffered responses must fit the FIFO.
    assign can_issue_o   = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_X;
    assign outstanding_o = outstanding;

    assign unexpected = data_r_valid_i & (outstanding == '0);
    assign drop       = data_r_valid_i & full & ~pop;
    assign over_issue = req_fire_i & ~can_issue_o;

    // Outstanding-request counter, saturating at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({req_fire_i, data_r_valid_i})
                2'b10: begin
                    if (outstanding != CNT_MAX) begin
                        outstanding <= outstanding + 1'b1;
                    end
                end
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - 1'b1;
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_o | unexpected | drop | over_issue;
        end
    end

endmodule

// File: tb/tb_ic_resp_buffer.sv
// Directed bench for ic_resp_buffer with a response scoreboard.
// Bypass checks are included when IC_RESP_BUF_BYPASS_EN is defined.
module tb_ic_resp_buffer;
    import ic_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_fire;
    logic        can_issue;
    logic        valid_in;
    logic [31:0] rdata_in;
    logic [3:0]  id_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_id;
    logic [2:0]  outstanding;
    logic        err;

    int checks = 0;
    int passes = 0;
    ic_resp_t sb[$];
    ic_resp_t e;

    ic_resp_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .req_fire_i     (req_fire),
        .can_issue_o    (can_issue),
        .data_r_valid_i (valid_in),
        .data_r_rdata_i (rdata_in),
        .data_r_ID_i    (id_in),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_ID_o      (resp_id),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare any handshake this cycle against the scoreboard, then advance.
    task automatic tick;
        #1;
        if (resp_valid && resp_ready) begin
            checks++;
            assert (sb.size() != 0) passes++;
            else $error("FAIL sb_underflow: observed %0h expected none",
                        resp_rdata);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_id", 32'(resp_id), 32'(e.id));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] i,
                        input bit expect_out);
        valid_in = 1'b1;
        rdata_in = d;
        id_in    = i;
        if (expect_out) sb.push_back('{rdata: d, id: i});
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        req_fire   = 1'b0;
        valid_in   = 1'b0;
        rdata_in   = '0;
        id_in      = '0;
        resp_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_outst", 32'(outstanding), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_can_issue", 32'(can_issue), 1);

        // Fill with ready low, then drain in order.
        req_fire = 1'b1;
        repeat (4) tick();
        req_fire = 1'b0;
        chk("t1_outst4", 32'(outstanding), 4);
        chk("t1_no_issue", 32'(can_issue), 0);
        for (int i = 0; i < 4; i++) send(32'hA0 + i, 4'(i), 1'b1);
        chk("t1_outst0", 32'(outstanding), 0);
        chk("t1_full_issue", 32'(can_issue), 0);
        chk("t1_valid", 32'(resp_valid), 1);
        chk("t1_head", resp_rdata, 32'hA0);
        chk("t1_err", 32'(err), 0);
        resp_ready = 1'b1;
        repeat (4) tick();
        chk("t1_drained", 32'(resp_valid), 0);
        chk("t1_issue", 32'(can_issue), 1);

        // Steady stream, responses two cycles after each request.
        for (int i = 0; i < 14; i++) begin
            req_fire = (i < 12);
            valid_in = (i >= 2);
            rdata_in = 32'hC0 + i;
            id_in    = 4'(i);
            if (i >= 2) sb.push_back('{rdata: 32'hC0 + i, id: 4'(i)});
            tick();
            if (i >= 1 && i <= 11) chk("t2_outst2", 32'(outstanding), 2);
        end
        req_fire = 1'b0;
        valid_in = 1'b0;
        repeat (2) tick();
        chk("t2_outst0", 32'(outstanding), 0);
        chk("t2_err", 32'(err), 0);
        chk("t2_sb", 32'(sb.size()), 0);

        // Unexpected response still delivered, error sticky.
        resp_ready = 1'b0;
        send(32'h55, 4'h5, 1'b1);
        chk("t3_err", 32'(err), 1);
        chk("t3_outst", 32'(outstanding), 0);
        tick();
        chk("t3_err_sticky", 32'(err), 1);
        chk("t3_valid", 32'(resp_valid), 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t3_empty", 32'(resp_valid), 0);
        chk("t3_sb", 32'(sb.size()), 0);

        // Push into a full FIFO without pop is dropped.
        do_reset();
        req_fire = 1'b1;
        repeat (4) tick();
        req_fire = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hD0 + i, 4'(i), 1'b1);
        chk("t4_err_pre", 32'(err), 0);
        send(32'hEE, 4'hF, 1'b0);
        chk("t4_err", 32'(err), 1);
        chk("t4_outst", 32'(outstanding), 0);
        chk("t4_no_issue", 32'(can_issue), 0);
        resp_ready = 1'b1;
        repeat (4) tick();
        resp_ready = 1'b0;
        chk("t4_empty", 32'(resp_valid), 0);
        chk("t4_sb", 32'(sb.size()), 0);

        // Full FIFO with simultaneous push and pop, pointers wrap.
        do_reset();
        req_fire = 1'b1;
        repeat (4) tick();
        req_fire = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hB0 + i, 4'(i), 1'b1);
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(32'hBB00 + i, 4'(i), 1'b1);
            chk("t5_full", 32'(can_issue), 0);
            chk("t5_valid", 32'(resp_valid), 1);
        end
        chk("t5_head", resp_rdata, 32'hBB06);
        repeat (4) tick();
        resp_ready = 1'b0;
        chk("t5_empty", 32'(resp_valid), 0);
        chk("t5_sb", 32'(sb.size()), 0);

        // Asynchronous reset mid-operation.
        do_reset();
        req_fire = 1'b1;
        repeat (4) tick();
        req_fire = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h60 + i, 4'(i), 1'b1);
        req_fire = 1'b1;
        tick();
        req_fire = 1'b0;
        chk("t6_outst2", 32'(outstanding), 2);
        chk("t6_valid", 32'(resp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(resp_valid), 0);
        chk("t6_async_rdata", resp_rdata, 0);
        chk("t6_async_id", 32'(resp_id), 0);
        chk("t6_async_outst", 32'(outstanding), 0);
        chk("t6_async_err", 32'(err), 0);
        chk("t6_async_issue", 32'(can_issue), 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_issue", 32'(can_issue), 1);
        resp_ready = 1'b1;
        send(32'h99, 4'h9, 1'b1);
        chk("t6_err", 32'(err), 1);
        tick();
        chk("t6_sb", 32'(sb.size()), 0);
        chk("t6_empty", 32'(resp_valid), 0);

`ifdef IC_RESP_BUF_BYPASS_EN
        // Bypass: empty FIFO, response consumed in the same cycle.
        do_reset();
        req_fire = 1'b1;
        tick();
        req_fire   = 1'b0;
        resp_ready = 1'b1;
        valid_in   = 1'b1;
        rdata_in   = 32'h77;
        id_in      = 4'h7;
        #1;
        chk("byp_valid", 32'(resp_valid), 1);
        chk("byp_rdata", resp_rdata, 32'h77);
        chk("byp_id", 32'(resp_id), 7);
        sb.push_back('{rdata: 32'h77, id: 4'h7});
        tick();
        valid_in = 1'b0;
        chk("byp_count0", 32'(resp_valid), 0);
        chk("byp_outst", 32'(outstanding), 0);
        chk("byp_err", 32'(err), 0);
        chk("byp_sb", 32'(sb.size()), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
